// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - LC-3 opcode constants and decoded-control type shared by the pipeline
package lc3_pkg;

   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_NOT  = 4'b1001;
   localparam logic [3:0] OP_LD   = 4'b0010;
   localparam logic [3:0] OP_LDI  = 4'b1010;
   localparam logic [3:0] OP_LDR  = 4'b0110;
   localparam logic [3:0] OP_LEA  = 4'b1110;
   localparam logic [3:0] OP_ST   = 4'b0011;
   localparam logic [3:0] OP_STI  = 4'b1011;
   localparam logic [3:0] OP_STR  = 4'b0111;
   localparam logic [3:0] OP_JMP  = 4'b1100;
   localparam logic [3:0] OP_JSR  = 4'b0100;
   localparam logic [3:0] OP_TRAP = 4'b1111;

   // Link register written by JSR/JSRR/TRAP
   localparam logic [2:0] R7 = 3'd7;

   typedef struct packed {
      logic [2:0] dr;
      logic       ld_reg;
      logic       use1;
      logic       use2;
   } lc3_ctrl_t;

endpackage

// File: rtl/lc3_decode_stage_if.sv
// rtl/lc3_decode_stage_if.sv - fetch, register-file, writeback and execute signals of the decode stage
interface lc3_decode_stage_if;

   logic        if_valid;
   logic [15:0] if_ir;
   logic [15:0] if_npc;
   logic        de_ready;

   logic [2:0]  sr1;
   logic [2:0]  sr2;
   logic [15:0] sr1_data;
   logic [15:0] sr2_data;

   logic        wb_ld;
   logic [2:0]  wb_dr;
   logic [15:0] wb_data;

   logic        flush;
   logic        ex_ready;
   logic        ex_valid;
   logic [15:0] ex_ir;
   logic [15:0] ex_npc;
   logic [15:0] ex_sr1_val;
   logic [15:0] ex_sr2_val;
   logic [2:0]  ex_dr;
   logic        ex_ld_reg;

   // Decode stage view
   modport slave (
      input  if_valid, if_ir, if_npc, sr1_data, sr2_data,
      input  wb_ld, wb_dr, wb_data, flush, ex_ready,
      output de_ready, sr1, sr2,
      output ex_valid, ex_ir, ex_npc, ex_sr1_val, ex_sr2_val, ex_dr, ex_ld_reg
   );

   // Surrounding pipeline view
   modport master (
      output if_valid, if_ir, if_npc, sr1_data, sr2_data,
      output wb_ld, wb_dr, wb_data, flush, ex_ready,
      input  de_ready, sr1, sr2,
      input  ex_valid, ex_ir, ex_npc, ex_sr1_val, ex_sr2_val, ex_dr, ex_ld_reg
   );

endinterface

// File: rtl/lc3_scoreboard.sv
// rtl/lc3_scoreboard.sv - per-register busy bits for writes issued but not yet written back
module lc3_scoreboard (
   input  logic       clk,
   input  logic       reset,
   input  logic       set_en,
   input  logic [2:0] set_idx,
   input  logic       clr_en,
   input  logic [2:0] clr_idx,
   input  logic       kill_en,
   input  logic [2:0] kill_idx,
   input  logic [2:0] q1_idx,
   input  logic [2:0] q2_idx,
   output logic       busy1,
   output logic       busy2
);

   logic [7:0] busy_q;
   logic [7:0] busy_d;

   // Clears applied first so a same-cycle set on the same register wins
   always_comb begin
      busy_d = busy_q;
      if (clr_en)  busy_d[clr_idx]  = 1'b0;
      if (kill_en) busy_d[kill_idx] = 1'b0;
      if (set_en)  busy_d[set_idx]  = 1'b1;
   end

   // Busy-bit state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) busy_q <= 8'h00;
      else       busy_q <= busy_d;
   end

   assign busy1 = busy_q[q1_idx];
   assign busy2 = busy_q[q2_idx];

endmodule

// File: rtl/lc3_decode_stage.sv
// rtl/lc3_decode_stage.sv - LC-3 decode/operand-fetch stage with scoreboard, bypass and ex handshake
import lc3_pkg::*;

module lc3_decode_stage (
   input logic               clk,
   input logic               reset,
   lc3_decode_stage_if.slave bus
);

   logic [3:0]  opcode;
   logic [2:0]  sr1_sel;
   logic [2:0]  sr2_sel;
   lc3_ctrl_t   ctrl;
   logic        byp1;
   logic        byp2;
   logic [15:0] sr1_val;
   logic [15:0] sr2_val;
   logic        busy1;
   logic        busy2;
   logic        hazard;
   logic        de_ready;
   logic        issue;

   logic        ex_valid_q,   ex_valid_d;
   logic [15:0] ex_ir_q,      ex_ir_d;
   logic [15:0] ex_npc_q,     ex_npc_d;
   logic [15:0] ex_sr1_val_q, ex_sr1_val_d;
   logic [15:0] ex_sr2_val_q, ex_sr2_val_d;
   logic [2:0]  ex_dr_q,      ex_dr_d;
   logic        ex_ld_reg_q,  ex_ld_reg_d;

   // Register-file addresses and decoded controls from the fetched word
   always_comb begin
      opcode  = bus.if_ir[15:12];
      sr1_sel = (opcode == OP_ST || opcode == OP_STI) ? bus.if_ir[11:9] : bus.if_ir[8:6];
      sr2_sel = (opcode == OP_STR) ? bus.if_ir[11:9] : bus.if_ir[2:0];
      ctrl    = '0;
      case (opcode)
         OP_ADD, OP_AND: begin
            ctrl.dr     = bus.if_ir[11:9];
            ctrl.ld_reg = 1'b1;
            ctrl.use1   = 1'b1;
            ctrl.use2   = ~bus.if_ir[5];
         end
         OP_NOT, OP_LDR: begin
            ctrl.dr     = bus.if_ir[11:9];
            ctrl.ld_reg = 1'b1;
            ctrl.use1   = 1'b1;
         end
         OP_LD, OP_LDI, OP_LEA: begin
            ctrl.dr     = bus.if_ir[11:9];
            ctrl.ld_reg = 1'b1;
         end
         OP_ST, OP_STI, OP_JMP: begin
            ctrl.use1   = 1'b1;
         end
         OP_STR: begin
            ctrl.use1   = 1'b1;
            ctrl.use2   = 1'b1;
         end
         OP_JSR: begin
            ctrl.dr     = R7;
            ctrl.ld_reg = 1'b1;
            ctrl.use1   = ~bus.if_ir[11];
         end
         OP_TRAP: begin
            ctrl.dr     = R7;
            ctrl.ld_reg = 1'b1;
         end
         default: ;
      endcase
   end

   // Writeback bypass, hazard detection and the accept decision
   always_comb begin
      byp1     = bus.wb_ld && (bus.wb_dr == sr1_sel);
      byp2     = bus.wb_ld && (bus.wb_dr == sr2_sel);
      sr1_val  = byp1 ? bus.wb_data : bus.sr1_data;
      sr2_val  = byp2 ? bus.wb_data : bus.sr2_data;
      hazard   = (ctrl.use1 && busy1 && !byp1) || (ctrl.use2 && busy2 && !byp2);
      de_ready = (!ex_valid_q || bus.ex_ready) && !hazard && !bus.flush;
      issue    = bus.if_valid && de_ready;
   end

   // Next ex_* contents: load on issue, drop when consumed or flushed, else hold
   always_comb begin
      ex_valid_d   = ex_valid_q;
      ex_ir_d      = ex_ir_q;
      ex_npc_d     = ex_npc_q;
      ex_sr1_val_d = ex_sr1_val_q;
      ex_sr2_val_d = ex_sr2_val_q;
      ex_dr_d      = ex_dr_q;
      ex_ld_reg_d  = ex_ld_reg_q;
      if (issue) begin
         ex_valid_d   = 1'b1;
         ex_ir_d      = bus.if_ir;
         ex_npc_d     = bus.if_npc;
         ex_sr1_val_d = sr1_val;
         ex_sr2_val_d = sr2_val;
         ex_dr_d      = ctrl.dr;
         ex_ld_reg_d  = ctrl.ld_reg;
      end else if (bus.flush || bus.ex_ready) begin
         ex_valid_d   = 1'b0;
      end
   end

   // Execute-side pipeline register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_valid_q   <= 1'b0;
         ex_ir_q      <= 16'h0000;
         ex_npc_q     <= 16'h0000;
         ex_sr1_val_q <= 16'h0000;
         ex_sr2_val_q <= 16'h0000;
         ex_dr_q      <= 3'd0;
         ex_ld_reg_q  <= 1'b0;
      end else begin
         ex_valid_q   <= ex_valid_d;
         ex_ir_q      <= ex_ir_d;
         ex_npc_q     <= ex_npc_d;
         ex_sr1_val_q <= ex_sr1_val_d;
         ex_sr2_val_q <= ex_sr2_val_d;
         ex_dr_q      <= ex_dr_d;
         ex_ld_reg_q  <= ex_ld_reg_d;
      end
   end

   // A flushed instruction in ex will never write back, so release its register
   lc3_scoreboard u_sb (
      .clk      (clk),
      .reset    (reset),
      .set_en   (issue && ctrl.ld_reg),
      .set_idx  (ctrl.dr),
      .clr_en   (bus.wb_ld),
      .clr_idx  (bus.wb_dr),
      .kill_en  (bus.flush && ex_valid_q && ex_ld_reg_q),
      .kill_idx (ex_dr_q),
      .q1_idx   (sr1_sel),
      .q2_idx   (sr2_sel),
      .busy1    (busy1),
      .busy2    (busy2)
   );

   assign bus.sr1        = sr1_sel;
   assign bus.sr2        = sr2_sel;
   assign bus.de_ready   = de_ready;
   assign bus.ex_valid   = ex_valid_q;
   assign bus.ex_ir      = ex_ir_q;
   assign bus.ex_npc     = ex_npc_q;
   assign bus.ex_sr1_val = ex_sr1_val_q;
   assign bus.ex_sr2_val = ex_sr2_val_q;
   assign bus.ex_dr      = ex_dr_q;
   assign bus.ex_ld_reg  = ex_ld_reg_q;

endmodule

// File: tb/tb_lc3_decode_stage.sv
// tb/tb_lc3_decode_stage.sv - randomized scoreboard bench for the LC-3 decode stage
module tb_lc3_decode_stage;
   import lc3_pkg::*;

   typedef struct {
      logic [15:0] ir;
      logic [15:0] npc;
      logic [15:0] v1;
      logic [15:0] v2;
      logic [2:0]  dr;
      logic        ld;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   lc3_decode_stage_if bus ();

   lc3_decode_stage dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [15:0] rf [8];
   assign bus.sr1_data = rf[bus.sr1];
   assign bus.sr2_data = rf[bus.sr2];

   exp_t       q[$];
   logic [2:0] infl[$];
   logic [7:0] mbusy;
   int         checks = 0;
   int         errors = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Instruction semantics from the ISA tables
   function automatic void ref_dec(input logic [15:0] ir,
                                   output logic [2:0] s1, output logic [2:0] s2,
                                   output bit u1, output bit u2, output bit ld,
                                   output logic [2:0] dr);
      logic [3:0] op;
      op = ir[15:12];
      s1 = (op inside {OP_ST, OP_STI}) ? ir[11:9] : ir[8:6];
      s2 = (op == OP_STR) ? ir[11:9] : ir[2:0];
      u1 = (op inside {OP_ADD, OP_AND, OP_NOT, OP_JMP, OP_LDR, OP_STR, OP_ST, OP_STI})
           || (op == OP_JSR && !ir[11]);
      u2 = ((op inside {OP_ADD, OP_AND}) && !ir[5]) || (op == OP_STR);
      ld = op inside {OP_ADD, OP_AND, OP_NOT, OP_LD, OP_LDI, OP_LDR, OP_LEA, OP_JSR, OP_TRAP};
      dr = (op inside {OP_JSR, OP_TRAP}) ? 3'd7 : ir[11:9];
   endfunction

   // One clock cycle: drive, predict, check combinational outputs, then commit the model
   task automatic step(input bit v, input logic [15:0] ir, input logic [15:0] npc,
                       input bit wl, input logic [2:0] wd, input logic [15:0] wdat,
                       input bit fl, input bit er, output bit issued);
      logic [2:0]  s1, s2, dr;
      bit          u1, u2, ld, haz, rdy, mv;
      logic [7:0]  nb;
      exp_t        e;
      bus.if_valid = v;
      bus.if_ir    = ir;
      bus.if_npc   = npc;
      bus.wb_ld    = wl;
      bus.wb_dr    = wd;
      bus.wb_data  = wdat;
      bus.flush    = fl;
      bus.ex_ready = er;
      #1;
      ref_dec(ir, s1, s2, u1, u2, ld, dr);
      mv  = (q.size() != 0);
      haz = (u1 && mbusy[s1] && !(wl && wd == s1)) || (u2 && mbusy[s2] && !(wl && wd == s2));
      rdy = (!mv || er) && !haz && !fl;
      chk("sr1", {13'd0, bus.sr1}, {13'd0, s1});
      chk("sr2", {13'd0, bus.sr2}, {13'd0, s2});
      chk("de_ready", {15'd0, bus.de_ready}, {15'd0, rdy});
      chk("scoreboard", {8'd0, dut.u_sb.busy_q}, {8'd0, mbusy});
      issued = v && rdy;
      e.ir  = ir;
      e.npc = npc;
      e.v1  = (wl && wd == s1) ? wdat : rf[s1];
      e.v2  = (wl && wd == s2) ? wdat : rf[s2];
      e.dr  = dr;
      e.ld  = ld;
      nb = mbusy;
      if (wl) nb[wd] = 1'b0;
      if (fl && mv && q[0].ld) nb[q[0].dr] = 1'b0;
      if (issued && ld) nb[dr] = 1'b1;
      if (mv && er && !fl && q[0].ld) infl.push_back(q[0].dr);
      @(posedge clk);
      #1;
      mbusy = nb;
      if (wl) rf[wd] = wdat;
      if (issued) q.push_back(e);
   endtask

   // Monitor: compares the presented ex_* against the oldest expectation
   initial begin
      forever begin
         @(negedge clk);
         if (reset) continue;
         chk("ex_valid", {15'd0, bus.ex_valid}, {15'd0, q.size() != 0});
         if (q.size() != 0) begin
            chk("ex_ir", bus.ex_ir, q[0].ir);
            chk("ex_npc", bus.ex_npc, q[0].npc);
            chk("ex_sr1_val", bus.ex_sr1_val, q[0].v1);
            chk("ex_sr2_val", bus.ex_sr2_val, q[0].v2);
            chk("ex_ld_reg", {15'd0, bus.ex_ld_reg}, {15'd0, q[0].ld});
            if (q[0].ld) chk("ex_dr", {13'd0, bus.ex_dr}, {13'd0, q[0].dr});
            if (bus.flush || bus.ex_ready) void'(q.pop_front());
         end
      end
   end

   initial begin
      bit          iss, have, v, er, fl, wl;
      logic [2:0]  wd;
      logic [15:0] cur_ir, cur_npc, wdat;

      for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
      rf[2] = 16'd5;
      rf[3] = 16'd7;
      mbusy = 8'h00;
      reset = 1'b1;
      bus.if_valid = 1'b0; bus.if_ir = 16'h0000; bus.if_npc = 16'h0000;
      bus.wb_ld = 1'b0; bus.wb_dr = 3'd0; bus.wb_data = 16'h0000;
      bus.flush = 1'b0; bus.ex_ready = 1'b0;
      #12;
      chk("rst ex_valid", {15'd0, bus.ex_valid}, 16'd0);
      chk("rst ex_ir", bus.ex_ir, 16'd0);
      chk("rst ex_npc", bus.ex_npc, 16'd0);
      chk("rst ex_sr1_val", bus.ex_sr1_val, 16'd0);
      chk("rst ex_sr2_val", bus.ex_sr2_val, 16'd0);
      chk("rst ex_dr", {13'd0, bus.ex_dr}, 16'd0);
      chk("rst ex_ld_reg", {15'd0, bus.ex_ld_reg}, 16'd0);
      chk("rst scoreboard", {8'd0, dut.u_sb.busy_q}, 16'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // ADD R1,R2,R3 then a dependent ADD R4,R1,#1 resolved by bypass
      step(1, 16'h1283, 16'h3001, 0, 3'd0, 16'h0, 0, 1, iss);
      chk("add issued", {15'd0, iss}, 16'd1);
      step(1, 16'h1861, 16'h3002, 0, 3'd0, 16'h0, 0, 1, iss);
      step(1, 16'h1861, 16'h3002, 0, 3'd0, 16'h0, 0, 1, iss);
      chk("dep stalled", {15'd0, iss}, 16'd0);
      step(1, 16'h1861, 16'h3002, 1, 3'd1, 16'h00AA, 0, 1, iss);
      chk("dep bypass issued", {15'd0, iss}, 16'd1);
      // Downstream stall for three cycles
      step(1, 16'h5020, 16'h3003, 0, 3'd0, 16'h0, 0, 0, iss);
      for (int i = 0; i < 3; i++) step(1, 16'hE402, 16'h3004, 0, 3'd0, 16'h0, 0, 0, iss);
      step(1, 16'hE402, 16'h3004, 0, 3'd0, 16'h0, 0, 1, iss);
      chk("after stall issued", {15'd0, iss}, 16'd1);
      // LEA R2 issued while writeback clears R2
      step(1, 16'hE402, 16'h3005, 1, 3'd2, 16'h1234, 0, 1, iss);
      // LD R5 held, then flushed
      step(1, 16'h2A00, 16'h3006, 0, 3'd0, 16'h0, 0, 1, iss);
      step(1, 16'h2A00, 16'h3007, 0, 3'd0, 16'h0, 0, 0, iss);
      step(1, 16'h1DE4, 16'h3008, 0, 3'd0, 16'h0, 1, 0, iss);
      chk("flush no issue", {15'd0, iss}, 16'd0);
      // STR R3,R4,#0, then immediate ADD whose IR[2:0] names busy R4
      step(1, 16'h7700, 16'h3009, 0, 3'd0, 16'h0, 0, 1, iss);
      step(1, 16'h1DE4, 16'h300A, 0, 3'd0, 16'h0, 0, 1, iss);
      chk("imm add no stall", {15'd0, iss}, 16'd1);
      step(0, 16'h0000, 16'h0000, 0, 3'd0, 16'h0, 0, 1, iss);

      // Randomized traffic with an out-of-order-free writeback model
      have = 0;
      cur_ir = 16'h0; cur_npc = 16'h0;
      for (int c = 0; c < 1500; c++) begin
         if (!have) begin
            cur_ir  = 16'($urandom);
            cur_npc = 16'($urandom);
            have    = 1;
         end
         v    = ($urandom % 4) != 0;
         er   = ($urandom % 4) != 0;
         fl   = ($urandom % 32) == 0;
         wl   = 0;
         wd   = 3'd0;
         wdat = 16'($urandom);
         if (infl.size() != 0 && ($urandom % 2) == 1) begin
            wl = 1;
            wd = infl.pop_front();
         end else if (($urandom % 8) == 0) begin
            wl = 1;
            wd = 3'($urandom % 8);
         end
         step(v, cur_ir, cur_npc, wl, wd, wdat, fl, er, iss);
         if (iss || fl) have = 0;
      end

      // Reset while work is pending
      step(1, 16'h2200, 16'h4000, 0, 3'd0, 16'h0, 0, 0, iss);
      step(1, 16'h1641, 16'h4001, 0, 3'd0, 16'h0, 0, 0, iss);
      reset = 1'b1;
      #1;
      chk("midrst ex_valid", {15'd0, bus.ex_valid}, 16'd0);
      chk("midrst scoreboard", {8'd0, dut.u_sb.busy_q}, 16'd0);
      q.delete();
      infl.delete();
      mbusy = 8'h00;
      #1;
      reset = 1'b0;
      step(1, 16'h1641, 16'h4001, 0, 3'd0, 16'h0, 0, 1, iss);
      chk("post reset issue", {15'd0, iss}, 16'd1);
      step(0, 16'h0000, 16'h0000, 0, 3'd0, 16'h0, 0, 1, iss);
      step(0, 16'h0000, 16'h0000, 0, 3'd0, 16'h0, 0, 1, iss);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lc3_decode_stage.md
# lc3_decode_stage

Decode/operand-fetch stage of the pipelined LC-3, between fetch and execute. It selects the SR1/SR2 read addresses for the 8×16 register file and captures that file's combinational read data. It tracks pending register writes with an 8-bit scoreboard, bypassing same-cycle writeback data or stalling on hazards. It hands one decoded instruction per cycle to execute under a valid/ready handshake.

## Interface
- No parameters; widths fixed by the LC-3 ISA (16-bit data, 3-bit register index).
- clk  in  1  sole clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- if_valid  in  1  fetch presents an instruction.
- if_ir  in  16  instruction word.
- if_npc  in  16  PC+1 of that instruction.
- de_ready  out  1  decode accepts the instruction this cycle.
- sr1  out  3  register-file SR1 read address (combinational from if_ir).
- sr2  out  3  register-file SR2 read address (combinational from if_ir).
- sr1_data  in  16  register-file read data for sr1.
- sr2_data  in  16  register-file read data for sr2.
- wb_ld  in  1  writeback writes a register this cycle.
- wb_dr  in  3  writeback destination.
- wb_data  in  16  writeback value.
- flush  in  1  execute redirect; kill younger work.
- ex_ready  in  1  execute consumes ex_* this cycle.
- ex_valid  out  1  ex_* holds a valid instruction.
- ex_ir  out  16  registered instruction.
- ex_npc  out  16  registered PC+1.
- ex_sr1_val  out  16  registered SR1 operand.
- ex_sr2_val  out  16  registered SR2 operand.
- ex_dr  out  3  registered destination register.
- ex_ld_reg  out  1  registered "writes a register" flag.

## Operation
- Address select:
  - sr1 = IR[11:9] for ST/STI, else IR[8:6].
  - sr2 = IR[11:9] for STR, else IR[2:0].
- Source use:
  - use1: ADD, AND, NOT, JMP, JSRR (JSR with IR[11]=0), LDR, STR, ST, STI.
  - use2: ADD/AND with IR[5]=0, STR.
- Destination:
  - ADD, AND, NOT, LD, LDI, LDR, LEA write IR[11:9].
  - JSR/JSRR and TRAP write R7.
  - All others write nothing (ld_reg=0).
- Operand value, per source: wb_data if wb_ld && wb_dr==src, else the register-file data. The register file writes on the same edge, so this bypass is mandatory.
- Hazard when a used source has its scoreboard bit set and is not being bypassed this cycle.
- de_ready = (!ex_valid || ex_ready) && !hazard && !flush.
- Issue = if_valid && de_ready. On issue, load all ex_* and set ex_valid=1.
- If the output is consumed or empty with no issue, set ex_valid=0. Otherwise hold ex_* unchanged.
- Scoreboard, per bit:
  - Set on issue with ld_reg for dr.
  - Clear on wb_ld for wb_dr.
  - Set wins when both hit the same bit in one cycle.
- flush, for one cycle:
  - ex_valid→0.
  - No issue that cycle.
  - If ex_valid && ex_ld_reg, clear scoreboard bit ex_dr, unless wb_ld targets the same register (clear either way).
  - Older in-flight scoreboard bits are untouched.

## Timing
- Reset values: ex_valid=0; ex_ir, ex_npc, ex_sr1_val, ex_sr2_val=0; ex_dr=0; ex_ld_reg=0; scoreboard=8'h00.
- Latency is 1 cycle: instruction accepted at edge N appears on ex_* after edge N.
- Throughput is 1 instruction/cycle with no hazards and ex_ready held high.
- sr1, sr2, de_ready are combinational. de_ready may depend on wb_* and ex_ready in the same cycle.
- ex_* are stable while ex_valid && !ex_ready (no overwrite, no drop).
- Reset mid-stall: all state clears asynchronously and pending scoreboard bits are lost. Downstream stages are reset together.

## Structure
- Shared lc3_pkg holds:
  - 4-bit opcode constants (OP_ADD=0001, OP_AND=0101, OP_NOT=1001, OP_LD=0010, OP_LDI=1010, OP_LDR=0110, OP_LEA=1110, OP_ST=0011, OP_STI=1011, OP_STR=0111, OP_JMP=1100, OP_JSR=0100, OP_TRAP=1111).
  - R7 index constant.
  - Decoded-control struct {dr, ld_reg, use1, use2}.
- One sub-module, lc3_scoreboard: 8 busy bits with set/clear/kill ports and a two-source busy query. Decode logic stays in the top.

## Test plan
- Reset, then ADD R1,R2,R3 (0x1283) with R2=5, R3=7, ex_ready=1 → next cycle ex_valid=1, sr1_val=5, sr2_val=7, ex_dr=1, ex_ld_reg=1; scoreboard bit1 set.
- ADD R1,… then ADD R4,R1,#1 (0x1861) with no writeback → de_ready=0 until wb_ld=1, wb_dr=1, wb_data=0x00AA; issued in that cycle with ex_sr1_val=0x00AA (bypass).
- ex_ready=0 for 3 cycles with ex_valid=1 → ex_* unchanged; de_ready=0; on ex_ready=1 the next instruction loads.
- Same-cycle set/clear: issue LEA R2 while wb_ld clears R2 → scoreboard bit2 remains 1.
- flush with ex_valid=1, ex_dr=5, ex_ld_reg=1 → next cycle ex_valid=0, bit5 cleared, no issue in the flush cycle.
- STR R3,R4,#0 (0x7700) → sr1=4, sr2=3; immediate ADD (IR[5]=1) with busy IR[2:0] register → no stall.
